// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if -- PLL-side and status signals of the lock supervisor.
//   pll_lock  : PLL LOCK output, asynchronous to clkin
//   relock    : one-cycle request to re-run the PLL reset sequence
//   pll_reset : PLL RESET pin drive, active-high
//   sys_rst   : active-high reset for the PLL output domain
//   ready     : high while the supervisor is in RUN
//   retry_cnt : lock timeouts seen, saturating at 255
//   loss_cnt  : lock losses seen in RUN, saturating at 255
// master = supervisor side, slave = PLL/system side.
interface pll_lock_supervisor_if;
  logic       pll_lock;
  logic       relock;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_lock, relock,
    output pll_reset, sys_rst, ready, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_lock, relock,
    input  pll_reset, sys_rst, ready, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor -- sequences PLL reset, waits for a stable lock, then
// releases the PLL-domain reset; re-sequences on lock loss or relock request.
// Ports:
//   clkin  : reference clock (also the PLL input clock)
//   reset  : synchronous active-high reset
//   sup    : pll_lock_supervisor_if.master (PLL handshake + status)
// Parameters: RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES.
// Macro PLL_SUP_STATUS_EN: when defined, retry_cnt/loss_cnt count events;
// when undefined both are tied to zero and no counter logic exists.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 10000,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic                         clkin,
  input  logic                         reset,
  pll_lock_supervisor_if.master        sup
);

  localparam int unsigned RW = $clog2(RST_CYCLES);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT);
  localparam int unsigned SW = $clog2(STABLE_CYCLES);

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          lock_s_q, lock_s_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0] stb_cnt_q, stb_cnt_d;
  logic          pll_reset_q, pll_reset_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;

  // Each phase counter runs only in its own state and is zero elsewhere,
  // so it is already cleared on entry.
  always_comb begin
    sync1_d   = sup.pll_lock;
    lock_s_d  = sync1_q;
    state_d   = state_q;
    rst_cnt_d = '0;
    to_cnt_d  = '0;
    stb_cnt_d = '0;
    unique case (state_q)
      PLL_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = WAIT_LOCK;
        else                       rst_cnt_d = rst_cnt_q + RW'(1);
      end
      WAIT_LOCK: begin
        if (lock_s_q)                   state_d = STABLE;
        else if (to_cnt_q == TO_LAST)   state_d = PLL_RST;
        else                            to_cnt_d = to_cnt_q + TW'(1);
      end
      STABLE: begin
        if (!lock_s_q)                  state_d = WAIT_LOCK;
        else if (stb_cnt_q == STB_LAST) state_d = RUN;
        else                            stb_cnt_d = stb_cnt_q + SW'(1);
      end
      RUN: begin
        if (!lock_s_q || sup.relock) state_d = PLL_RST;
      end
      default: state_d = PLL_RST;
    endcase
    // Outputs decode the next state so they switch on the transition edge.
    pll_reset_d = (state_d == PLL_RST);
    sys_rst_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= PLL_RST;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      lock_s_q    <= lock_s_d;
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
    end
  end

  assign sup.pll_reset = pll_reset_q;
  assign sup.sys_rst   = sys_rst_q;
  assign sup.ready     = ready_q;

`ifdef PLL_SUP_STATUS_EN
  logic [7:0] retry_cnt_q, retry_cnt_d;
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic       timeout_evt;
  logic       loss_evt;

  // A lock loss coinciding with relock still counts as a loss.
  always_comb begin
    timeout_evt = (state_q == WAIT_LOCK) && (state_d == PLL_RST);
    loss_evt    = (state_q == RUN) && !lock_s_q;
    retry_cnt_d = retry_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    if (timeout_evt && (retry_cnt_q != '1)) retry_cnt_d = retry_cnt_q + 8'd1;
    if (loss_evt && (loss_cnt_q != '1))     loss_cnt_d  = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      retry_cnt_q <= '0;
      loss_cnt_q  <= '0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign sup.retry_cnt = retry_cnt_q;
  assign sup.loss_cnt  = loss_cnt_q;
`else
  assign sup.retry_cnt = '0;
  assign sup.loss_cnt  = '0;
`endif

endmodule
